permutation_sequencer: RTL and testbench

//  Sequences the Ascon permutation over the shared one-round datapath
//  (constant addition -> substitution layer -> diffusion), one round per clock.

---
 rtl/permutation_sequencer_pkg.sv | 79 +++++++
 rtl/permutation_sequencer_round.sv | 19 +
 rtl/permutation_sequencer.sv | 101 ++++++++++
 tb/tb_permutation_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/permutation_sequencer_pkg.sv
// Shared Ascon types, round-count constants and the three round-step
// functions used by the one-round datapath.
package ascon_pack;

    // Five 64-bit lanes x0..x4; index 0 is x0.
    typedef logic [4:0][63:0] type_state;

    // Permutation sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_perm_fsm;

    localparam int         NB_ROUNDS_A       = 12;
    localparam int         NB_ROUNDS_B       = 6;
    localparam logic [3:0] ROUND_IDX_B_FIRST = 4'd6;
    localparam logic [3:0] ROUND_IDX_LAST    = 4'd11;

    // c_r = {15 - r, r}: 0xF0, 0xE1, ... 0x4B for r = 0..11.
    function automatic logic [7:0] round_constant(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    // Rotate a lane right by a fixed amount (callers pass constants only).
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Round constant enters the low byte of x2 only.
    function automatic type_state constant_addition(input type_state s, input logic [3:0] r);
        type_state t;
        t = s;
        t[2][7:0] = s[2][7:0] ^ round_constant(r);
        return t;
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once.
    function automatic type_state substitution_layer(input type_state s);
        type_state  o;
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [63:0] y0, y1, y2, y3, y4;
        x0 = s[0] ^ s[4];
        x1 = s[1];
        x2 = s[2] ^ s[1];
        x3 = s[3];
        x4 = s[4] ^ s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        y0 = x0 ^ t1;
        y1 = x1 ^ t2;
        y2 = x2 ^ t3;
        y3 = x3 ^ t4;
        y4 = x4 ^ t0;
        // Output mixing; y1 uses the post-chi y0, y0 uses the post-chi y4.
        o[1] = y1 ^ y0;
        o[0] = y0 ^ y4;
        o[3] = y3 ^ y2;
        o[2] = ~y2;
        o[4] = y4;
        return o;
    endfunction

    // Per-lane linear diffusion with the Ascon rotation pairs.
    function automatic type_state diffusion(input type_state s);
        type_state o;
        o[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        o[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        o[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
        o[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        o[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
        return o;
    endfunction

endpackage

// File: rtl/permutation_sequencer_round.sv
// One Ascon round, purely combinational:
// constant addition -> substitution layer -> diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  logic [3:0] round_i,
    input  type_state  state_i,
    output type_state  state_o
);

    // Intermediate stages kept as named nets so they can be probed.
    type_state state_cadd;
    type_state state_sbox;

    assign state_cadd = constant_addition(state_i, round_i);
    assign state_sbox = substitution_layer(state_cadd);
    assign state_o    = diffusion(state_sbox);

endmodule

// File: rtl/permutation_sequencer.sv
// Sequences p^a (rounds 0..11) or p^b (rounds 6..11) over one shared round
// datapath, one round per clock, with a start/busy/done handshake.
//
// Handshake: start_i is sampled only while IDLE; the accepted edge loads
// state_i and mode_i. busy_o stays high through RUN and DONE, and done_o is
// a one-cycle pulse in DONE while state_o holds the permuted result.
// start_i seen in RUN or DONE is dropped, never queued.
module permutation_sequencer
    import ascon_pack::*;
(
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  type_state    state_i,
    output type_state    state_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o,
    output type_perm_fsm fsm_state_o
);

    type_perm_fsm fsm_q,   fsm_d;
    logic [3:0]   round_q, round_d;
    logic         mode_q,  mode_d;
    type_state    state_q, state_d;
    type_state    round_state;
    logic         round_illegal;

    ascon_round u_round (
        .round_i (round_q),
        .state_i (state_q),
        .state_o (round_state)
    );

    // Counter values above 11, or below 6 in p^b, can only come from a fault.
    assign round_illegal = (round_q > ROUND_IDX_LAST) ||
                           (mode_q && (round_q < ROUND_IDX_B_FIRST));

    // State register, round counter, latched mode and FSM state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

    // Next-state logic: load on accepted start, one round per RUN cycle.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        mode_d  = mode_q;
        state_d = state_q;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    mode_d  = mode_i;
                    round_d = mode_i ? ROUND_IDX_B_FIRST : 4'd0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (round_illegal) begin
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else begin
                    state_d = round_state;
                    if (round_q == ROUND_IDX_LAST) begin
                        // Counter parks at 0 rather than stepping to 12.
                        round_d = 4'd0;
                        fsm_d   = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                round_d = 4'd0;
                fsm_d   = IDLE;
            end
        endcase
    end

    assign state_o     = state_q;
    assign round_o     = round_q;
    assign busy_o      = (fsm_q != IDLE);
    assign done_o      = (fsm_q == DONE);
    assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Bench for permutation_sequencer: directed Ascon-128 init vectors, zero
// state, random states/modes, held start, late start pulses and async reset,
// all compared against a table-driven Ascon permutation model.
module tb_permutation_sequencer;
    import ascon_pack::*;

    logic         clock_i;
    logic         reset_i;
    logic         start_i;
    logic         mode_i;
    type_state    state_i;
    type_state    state_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;
    type_perm_fsm fsm_state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [319:0] exp_q[$];

    permutation_sequencer dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .state_i     (state_i),
        .state_o     (state_o),
        .round_o     (round_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fsm_state_o (fsm_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [7:0] ref_const(input int r);
        return 8'((((15 - r) << 4) | r) & 255);
    endfunction

    // Rounds first_r..11 applied column by column through the S-box table.
    function automatic type_state ref_perm(input type_state s_in, input int first_r);
        type_state  s;
        logic [4:0] col;
        logic [4:0] sb;
        s = s_in;
        for (int r = first_r; r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ ref_const(r);
            for (int b = 0; b < 64; b++) begin
                col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
                sb  = SBOX[col];
                for (int j = 0; j < 5; j++) s[j][b] = sb[4 - j];
            end
            s[0] = s[0] ^ rot(s[0], 19) ^ rot(s[0], 28);
            s[1] = s[1] ^ rot(s[1], 61) ^ rot(s[1], 39);
            s[2] = s[2] ^ rot(s[2],  1) ^ rot(s[2],  6);
            s[3] = s[3] ^ rot(s[3], 10) ^ rot(s[3], 17);
            s[4] = s[4] ^ rot(s[4],  7) ^ rot(s[4], 41);
        end
        return s;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int j = 0; j < 5; j++) s[j] = {$urandom(), $urandom()};
        return s;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset_i = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        state_i = '0;
        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    // One permutation; poke re-pulses start at round index 3 and in DONE.
    task automatic run_and_check(input logic mode, input type_state st, input bit poke, input string name);
        int        n;
        int        first;
        type_state exp_s;
        logic [7:0] probe;
        n     = mode ? 6 : 12;
        first = mode ? 6 : 0;
        exp_s = ref_perm(st, first);
        exp_q.push_back(exp_s);
        @(negedge clock_i);
        start_i = 1'b1;
        mode_i  = mode;
        state_i = st;
        @(negedge clock_i);
        start_i = 1'b0;
        state_i = rand_state();
        for (int i = 0; i < n; i++) begin
            check({name, " round"}, 320'(round_o), 320'(first + i));
            check({name, " busy"}, 320'(busy_o), 320'(1));
            check({name, " early_done"}, 320'(done_o), 320'(0));
            if (i == 0) begin
                probe = dut.u_round.state_cadd[2][7:0] ^ state_o[2][7:0];
                check({name, " first_const"}, 320'(probe), 320'(ref_const(first)));
            end
            if (poke && i == 3) begin
                start_i = 1'b1;
                mode_i  = ~mode;
                state_i = rand_state();
            end else begin
                start_i = 1'b0;
            end
            @(negedge clock_i);
        end
        check({name, " done"}, 320'(done_o), 320'(1));
        check({name, " busy_in_done"}, 320'(busy_o), 320'(1));
        check({name, " result"}, state_o, exp_q.pop_front());
        if (poke) begin
            start_i = 1'b1;
            state_i = rand_state();
        end
        @(negedge clock_i);
        start_i = 1'b0;
        check({name, " done_pulse"}, 320'(done_o), 320'(0));
        check({name, " idle"}, 320'(busy_o), 320'(0));
        check({name, " hold"}, state_o, exp_s);
        @(negedge clock_i);
        check({name, " still_idle"}, 320'(busy_o), 320'(0));
    endtask

    // ---------------- stimulus ----------------
    type_state init_st;
    type_state zero_st;
    int        done_seen;

    initial begin
        do_reset();
        #1;
        check("rst state", state_o, 320'(0));
        check("rst round", 320'(round_o), 320'(0));
        check("rst busy", 320'(busy_o), 320'(0));
        check("rst done", 320'(done_o), 320'(0));
        check("rst fsm", 320'(fsm_state_o), 320'(IDLE));

        init_st[0] = 64'h80400c0600000000;
        init_st[1] = 64'h0001020304050607;
        init_st[2] = 64'h08090a0b0c0d0e0f;
        init_st[3] = 64'h0001020304050607;
        init_st[4] = 64'h08090a0b0c0d0e0f;
        zero_st    = '0;

        run_and_check(1'b0, init_st, 1'b0, "pa_init");
        run_and_check(1'b1, init_st, 1'b0, "pb_init");
        run_and_check(1'b0, init_st, 1'b1, "pa_poke");
        run_and_check(1'b0, zero_st, 1'b0, "pa_zero");
        for (int t = 0; t < 6; t++) begin
            run_and_check(1'($urandom_range(0, 1)), rand_state(), 1'($urandom_range(0, 1)), "rand");
        end

        // start held high: a new p^a every 14 cycles, state_i re-sampled.
        exp_q.delete();
        mode_i = 1'b0;
        for (int m = 0; m <= 42; m++) begin
            @(negedge clock_i);
            if (m > 0) begin
                check("held done", 320'(done_o), 320'((m % 14) == 13));
                if (done_o) begin
                    if (exp_q.size() == 0) check("held queue", 320'(0), 320'(1));
                    else check("held result", state_o, exp_q.pop_front());
                end
            end
            if (m < 42) begin
                start_i = 1'b1;
                state_i = rand_state();
                if ((m % 14) == 0) exp_q.push_back(ref_perm(state_i, 0));
            end else begin
                start_i = 1'b0;
            end
        end
        @(negedge clock_i);
        check("held end busy", 320'(busy_o), 320'(0));
        check("held queue empty", 320'(exp_q.size()), 320'(0));

        // Asynchronous reset in the middle of a p^a run.
        @(negedge clock_i);
        start_i = 1'b1;
        mode_i  = 1'b0;
        state_i = rand_state();
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (5) @(negedge clock_i);
        check("mid round5", 320'(round_o), 320'(5));
        #2;
        reset_i = 1'b1;
        #1;
        check("mid rst state", state_o, 320'(0));
        check("mid rst round", 320'(round_o), 320'(0));
        check("mid rst busy", 320'(busy_o), 320'(0));
        check("mid rst done", 320'(done_o), 320'(0));
        check("mid rst fsm", 320'(fsm_state_o), 320'(IDLE));
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_i);
            if (done_o) done_seen++;
        end
        check("mid no done", 320'(done_seen), 320'(0));
        check("mid idle", 320'(fsm_state_o), 320'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
